// File: rtl/glitcbus_slave_if.sv
// ============================================================================
// Module : glitcbus_slave_if
// Brief  : GLITCBUS pad-side and local-register-side signal bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface glitcbus_slave_if #(
  parameter int ERR_CNT_BITS = 8
) ();
  logic                    gsel_b_i;
  logic                    grdwr_b_i;
  logic [7:0]              gad_i;
  logic [7:0]              gad_o;
  logic                    gad_t_o;
  logic [15:0]             adr_o;
  logic [31:0]             wr_dat_o;
  logic                    wr_stb_o;
  logic                    rd_stb_o;
  logic [31:0]             rd_dat_i;
  logic                    rd_ack_i;
  logic [ERR_CNT_BITS-1:0] abort_cnt_o;
  logic [ERR_CNT_BITS-1:0] timeout_cnt_o;
  logic                    busy_o;

  modport slave (
    input  gsel_b_i, grdwr_b_i, gad_i, rd_dat_i, rd_ack_i,
    output gad_o, gad_t_o, adr_o, wr_dat_o, wr_stb_o, rd_stb_o,
           abort_cnt_o, timeout_cnt_o, busy_o
  );

  modport master (
    output gsel_b_i, grdwr_b_i, gad_i, rd_dat_i, rd_ack_i,
    input  gad_o, gad_t_o, adr_o, wr_dat_o, wr_stb_o, rd_stb_o,
           abort_cnt_o, timeout_cnt_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/glitcbus_slave.sv
// ============================================================================
// Module : glitcbus_slave
// Brief  : GLITCBUS responder; byte-serial bus to single-cycle local strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module glitcbus_slave #(
  parameter logic [31:0] RD_TIMEOUT_DATA = 32'hDEADBEEF,
  parameter int          ERR_CNT_BITS    = 8
) (
  input  wire              clk_i,
  input  wire              rst_n_i,
  glitcbus_slave_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_LO = 4'd1,
    TURN    = 4'd2,
    WR_B3   = 4'd3,
    WR_B2   = 4'd4,
    WR_B1   = 4'd5,
    WR_B0   = 4'd6,
    WR_STB  = 4'd7,
    RD_WAIT = 4'd8,
    RD_B3   = 4'd9,
    RD_B2   = 4'd10,
    RD_B1   = 4'd11,
    RD_B0   = 4'd12
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [15:0]             r_adr, w_adr_nxt;
  logic [31:0]             r_wr_dat, w_wr_dat_nxt;
  logic [31:0]             r_rd_dat, w_rd_dat_nxt;
  logic [31:0]             w_rd_word;
  logic [7:0]              r_gad_o, w_gad_o_nxt;
  logic                    r_gad_t, w_gad_t_nxt;
  logic                    r_wr_stb, w_wr_stb_nxt;
  logic                    r_rd_stb, w_rd_stb_nxt;
  logic                    r_dir_rd, w_dir_rd_nxt;
  logic                    r_ack_seen, w_ack_seen_nxt;
  logic                    w_abort_inc, w_timeout_inc;
  logic [ERR_CNT_BITS-1:0] r_abort_cnt, r_timeout_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_adr         <= '0;
      r_wr_dat      <= '0;
      r_rd_dat      <= '0;
      r_gad_o       <= '0;
      r_gad_t       <= 1'b1;
      r_wr_stb      <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_dir_rd      <= 1'b0;
      r_ack_seen    <= 1'b0;
      r_abort_cnt   <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_adr      <= w_adr_nxt;
      r_wr_dat   <= w_wr_dat_nxt;
      r_rd_dat   <= w_rd_dat_nxt;
      r_gad_o    <= w_gad_o_nxt;
      r_gad_t    <= w_gad_t_nxt;
      r_wr_stb   <= w_wr_stb_nxt;
      r_rd_stb   <= w_rd_stb_nxt;
      r_dir_rd   <= w_dir_rd_nxt;
      r_ack_seen <= w_ack_seen_nxt;
      if (w_abort_inc && (r_abort_cnt != '1))
        r_abort_cnt <= r_abort_cnt + 1'b1;
      if (w_timeout_inc && (r_timeout_cnt != '1))
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_adr_nxt      = r_adr;
    w_wr_dat_nxt   = r_wr_dat;
    w_rd_dat_nxt   = r_rd_dat;
    w_rd_word      = r_rd_dat;
    w_gad_o_nxt    = r_gad_o;
    w_gad_t_nxt    = r_gad_t;
    w_wr_stb_nxt   = 1'b0;
    w_rd_stb_nxt   = 1'b0;
    w_dir_rd_nxt   = r_dir_rd;
    w_ack_seen_nxt = r_ack_seen;
    w_abort_inc    = 1'b0;
    w_timeout_inc  = 1'b0;

    // Early deselect abandons the transfer and frees the pad on the same edge.
    if (bus.gsel_b_i && (r_state != IDLE) && (r_state != WR_STB)) begin
      w_state_nxt = IDLE;
      w_gad_t_nxt = 1'b1;
      w_abort_inc = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.gsel_b_i) begin
            w_adr_nxt[15:8] = bus.gad_i;
            w_dir_rd_nxt    = bus.grdwr_b_i;
            w_ack_seen_nxt  = 1'b0;
            w_state_nxt     = ADDR_LO;
          end
        end
        ADDR_LO: begin
          w_adr_nxt[7:0] = bus.gad_i;
          w_rd_stb_nxt   = r_dir_rd;
          w_state_nxt    = TURN;
        end
        TURN: begin
          if (r_dir_rd) begin
            if (bus.rd_ack_i) begin
              w_rd_dat_nxt   = bus.rd_dat_i;
              w_ack_seen_nxt = 1'b1;
            end
            w_state_nxt = RD_WAIT;
          end else begin
            w_state_nxt = WR_B3;
          end
        end
        WR_B3: begin
          w_wr_dat_nxt[31:24] = bus.gad_i;
          w_state_nxt         = WR_B2;
        end
        WR_B2: begin
          w_wr_dat_nxt[23:16] = bus.gad_i;
          w_state_nxt         = WR_B1;
        end
        WR_B1: begin
          w_wr_dat_nxt[15:8] = bus.gad_i;
          w_state_nxt        = WR_B0;
        end
        WR_B0: begin
          w_wr_dat_nxt[7:0] = bus.gad_i;
          w_wr_stb_nxt      = 1'b1;
          w_state_nxt       = WR_STB;
        end
        WR_STB: w_state_nxt = IDLE;
        RD_WAIT: begin
          // A late (n+3) ack goes straight to the pad without an extra cycle.
          if (bus.rd_ack_i)
            w_rd_word = bus.rd_dat_i;
          else if (r_ack_seen)
            w_rd_word = r_rd_dat;
          else begin
            w_rd_word     = RD_TIMEOUT_DATA;
            w_timeout_inc = 1'b1;
          end
          w_rd_dat_nxt = w_rd_word;
          w_gad_o_nxt  = w_rd_word[31:24];
          w_gad_t_nxt  = 1'b0;
          w_state_nxt  = RD_B3;
        end
        RD_B3: begin
          w_gad_o_nxt = r_rd_dat[23:16];
          w_state_nxt = RD_B2;
        end
        RD_B2: begin
          w_gad_o_nxt = r_rd_dat[15:8];
          w_state_nxt = RD_B1;
        end
        RD_B1: begin
          w_gad_o_nxt = r_rd_dat[7:0];
          w_state_nxt = RD_B0;
        end
        RD_B0: begin
          w_gad_t_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
        default: begin
          w_gad_t_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.gad_o         = r_gad_o;
  assign bus.gad_t_o       = r_gad_t;
  assign bus.adr_o         = r_adr;
  assign bus.wr_dat_o      = r_wr_dat;
  assign bus.wr_stb_o      = r_wr_stb;
  assign bus.rd_stb_o      = r_rd_stb;
  assign bus.abort_cnt_o   = r_abort_cnt;
  assign bus.timeout_cnt_o = r_timeout_cnt;
  assign bus.busy_o        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/glitcbus_slave.md
Name: glitcbus_slave

Overview:
- GLITCBUS responder inside each GLITC FPGA. It is the far end of the TISC quad GLITCBUS master.
- Decodes byte-serial GLITCBUS transactions (GSEL_B / GRDWR_B / 8-bit GAD) into single-cycle strobes on the local register bus.
- Returns read data on GAD.
- Runs on clk_i, which is the received GCLK. All bus inputs are sampled on the rising edge.

Parameters:
- RD_TIMEOUT_DATA, 32'hDEADBEEF, word returned when local read ack is missing.
- ERR_CNT_BITS, 8, width of the saturating abort and timeout counters.

Ports:
- clk_i  in  1  GLITCBUS clock (GCLK)
- rst_n_i  in  1  asynchronous active-low reset
- gsel_b_i  in  1  chip select from master, active low
- grdwr_b_i  in  1  1 = read, 0 = write; sampled in the first select cycle only
- gad_i  in  8  GAD input from pad
- gad_o  out  8  GAD output to pad (registered; packed to IOB)
- gad_t_o  out  1  GAD tristate, 1 = hi-Z (registered; packed to IOB)
- adr_o  out  16  local register address
- wr_dat_o  out  32  local write data
- wr_stb_o  out  1  one-cycle local write strobe
- rd_stb_o  out  1  one-cycle local read strobe
- rd_dat_i  in  32  local read data
- rd_ack_i  in  1  local read data valid
- abort_cnt_o  out  ERR_CNT_BITS  count of transactions aborted by early GSEL_B release
- timeout_cnt_o  out  ERR_CNT_BITS  count of read ack timeouts
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst_n_i=0) forces:
  - state = IDLE, gad_t_o = 1, gad_o = 0.
  - adr_o = 0, wr_dat_o = 0, all strobes = 0, both counters = 0.
- Bus cycle numbering: cycle n is the first cycle with gsel_b_i=0 sampled in IDLE.
- States: IDLE, ADDR_LO, TURN, WR_B3, WR_B2, WR_B1, WR_B0, WR_STB, RD_WAIT, RD_B3, RD_B2, RD_B1, RD_B0.
- Cycle n (IDLE, gsel_b_i=0):
  - Latch gad_i into adr_o[15:8] and grdwr_b_i into a direction flag.
  - Go to ADDR_LO.
- Cycle n+1 (ADDR_LO): latch gad_i into adr_o[7:0]; go to TURN.
- Cycle n+2 (TURN): bus turnaround; nothing is driven.
  - Read: rd_stb_o = 1 for this cycle only (registered, so adr_o is already valid); go to RD_WAIT.
  - Write: go to WR_B3.
- Write path:
  - Cycles n+3..n+6 (WR_B3..WR_B0): capture gad_i into wr_dat_o[31:24], [23:16], [15:8], [7:0] in that order.
  - Cycle n+7 (WR_STB): wr_stb_o = 1 for one cycle, with wr_dat_o and adr_o stable; return to IDLE.
- Read path:
  - rd_ack_i sampled high in cycle n+2 or n+3 latches rd_dat_i; a cycle-n+3 ack is forwarded the same edge.
  - No ack by the end of n+3: use RD_TIMEOUT_DATA and increment timeout_cnt_o (saturating).
  - An ack outside that window is ignored.
  - End of n+3 (RD_WAIT): gad_t_o <= 0 and gad_o <= byte3.
  - Bus shows D3, D2, D1, D0 in cycles n+4..n+7 (states RD_B3..RD_B0).
  - End of n+7: gad_t_o <= 1, so the bus is hi-Z from n+8; return to IDLE.
- Abort rule: gsel_b_i sampled 1 in any state other than IDLE or WR_STB:
  - Next state = IDLE; gad_t_o <= 1 on the same edge.
  - No wr_stb_o is issued; abort_cnt_o increments (saturating).
  - An rd_stb_o already issued is not recalled.
- gsel_b_i may stay low through WR_STB and through the first IDLE cycle; that is not an abort.
- A new transaction is recognised only from IDLE with gsel_b_i=0.
- gsel_b_i still low after completion is treated as a new transaction start. The master guarantees at least 2 deselected cycles between transactions.
- gad_t_o is never 0 in any cycle before n+4. This guarantees no bus contention during turnaround.
- Counters saturate at all-ones; they clear only on reset.
- Reset asserted mid-transaction releases the bus asynchronously (gad_t_o = 1 immediately).

Test Plan:
- Write adr 0x1234, data 0xA1B2C3D4 (GAD 12,34,xx,A1,B2,C3,D4) → wr_stb_o one cycle at n+7, adr_o=0x1234, wr_dat_o=0xA1B2C3D4, gad_t_o stays 1 throughout.
- Read adr 0x00FF, rd_ack_i in n+2 with 0x01020304 → rd_stb_o at n+2; GAD=01,02,03,04 in n+4..n+7; gad_t_o=0 exactly n+4..n+7.
- Read with rd_ack_i only in n+3 carrying 0xCAFEF00D → CA,FE,F0,0D on the bus; timeout_cnt_o unchanged.
- Read with no ack → DE,AD,BE,EF on the bus; timeout_cnt_o 0→1; 256 timeouts saturate at 0xFF.
- Write aborted by gsel_b_i=1 during WR_B1 → no wr_stb_o, abort_cnt_o=1, IDLE next cycle; a following legal write completes normally.
- rst_n_i pulsed low during RD_B2 → gad_t_o=1 asynchronously; all outputs at reset values; next read works.
